send_control: RTL and testbench

SEND_CONTROL -- requirements
Module: send_control

---
 rtl/send_ctrl_pkg.sv | 12 +
 rtl/sync_2ff.sv | 34 +++
 rtl/send_control.sv | 133 +++++++++++++
 tb/tb_send_control.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/send_ctrl_pkg.sv
// send_ctrl_pkg: shared types and defaults
// for the toggle-handshake sender.
package send_ctrl_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } send_state_e;

  localparam int WIDTH_D_DEF = 8;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a
// single level crossing into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s1_d;
  logic s2_q;
  logic s2_d;

  // shift the async level through two flops
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // sync chain registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/send_control.sv
// send_control: toggle-request sender with level-compare ack.
// Optional ack timeout enabled by macro SEND_TIMEOUT_EN.
module send_control
  import send_ctrl_pkg::*;
#(
  parameter int WIDTH_D     = WIDTH_D_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               bclk,
  input  logic               brst_n,
  input  logic [WIDTH_D-1:0] bdin,
  input  logic               bload,
  output logic               bready,
  input  logic               a_ack,
  output logic [WIDTH_D-1:0] bdata,
  output logic               b_req,
  output logic               bdone,
  output logic               berr
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  send_state_e        state_q;
  send_state_e        state_d;
  logic [WIDTH_D-1:0] bdata_q;
  logic [WIDTH_D-1:0] bdata_d;
  logic               b_req_q;
  logic               b_req_d;
  logic               bdone_q;
  logic               bdone_d;
  logic               a_ack_s;
  logic               ack_match;

  sync_2ff u_sync (
    .clk   (bclk),
    .rst_n (brst_n),
    .d     (a_ack),
    .q     (a_ack_s)
  );

  // level compare: a missed ack edge still matches later
  assign ack_match = (a_ack_s == b_req_q);

  // next-state, capture and toggle
  always_comb begin
    state_d = state_q;
    bdata_d = bdata_q;
    b_req_d = b_req_q;
    bdone_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bload && ack_match) begin
          bdata_d = bdin;
          b_req_d = ~b_req_q;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_match) begin
          state_d = IDLE;
          bdone_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and payload registers
  always_ff @(posedge bclk or negedge brst_n) begin
    if (!brst_n) begin
      state_q <= IDLE;
      bdata_q <= '0;
      b_req_q <= 1'b0;
      bdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bdata_q <= bdata_d;
      b_req_q <= b_req_d;
      bdone_q <= bdone_d;
    end
  end

  assign bready = (state_q == IDLE);
  assign bdata  = bdata_q;
  assign b_req  = b_req_q;
  assign bdone  = bdone_q;

`ifdef SEND_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] T_MAX = CW'(TIMEOUT_CYC);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          berr_q;
  logic          berr_d;

  // saturating wait counter, cleared on each new transfer
  always_comb begin
    cnt_d  = cnt_q;
    berr_d = berr_q;
    if (state_q == IDLE) begin
      if (state_d == WAIT_ACK) begin
        cnt_d = '0;
      end
    end else begin
      if (cnt_q != T_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end
      if (cnt_d == T_MAX) begin
        berr_d = 1'b1;
      end
    end
  end

  // timeout registers; berr is sticky until reset
  always_ff @(posedge bclk or negedge brst_n) begin
    if (!brst_n) begin
      cnt_q  <= '0;
      berr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      berr_q <= berr_d;
    end
  end

  assign berr = berr_q;
`else
  assign berr = 1'b0;
`endif

endmodule

// File: tb/tb_send_control.sv
// tb_send_control: randomized and directed checks of
// send_control against a transfer-level reference model.
module tb_send_control;

  localparam int W = 8;
  localparam int T = 10;

  logic         bclk;
  logic         brst_n;
  logic [W-1:0] bdin;
  logic         bload;
  logic         bready;
  logic         a_ack;
  logic [W-1:0] bdata;
  logic         b_req;
  logic         bdone;
  logic         berr;

  int checks;
  int failures;

`ifdef SEND_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  send_control #(
    .WIDTH_D     (W),
    .TIMEOUT_CYC (T)
  ) dut (
    .bclk   (bclk),
    .brst_n (brst_n),
    .bdin   (bdin),
    .bload  (bload),
    .bready (bready),
    .a_ack  (a_ack),
    .bdata  (bdata),
    .b_req  (b_req),
    .bdone  (bdone),
    .berr   (berr)
  );

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  // reference model: one outstanding transfer, ack seen
  // two clocks late, sticky error after T waiting cycles
  bit       m_busy;
  bit [W-1:0] m_data;
  bit       m_req;
  bit       m_done;
  bit       m_err;
  int       m_waited;
  bit       m_hist [2];

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy   = 0;
    m_data   = '0;
    m_req    = 0;
    m_done   = 0;
    m_err    = 0;
    m_waited = 0;
    m_hist[0] = 0;
    m_hist[1] = 0;
  endtask

  task automatic check_all();
    chk("bready", bready, !m_busy);
    chk("bdata", bdata, m_data);
    chk("b_req", b_req, m_req);
    chk("bdone", bdone, m_done);
    chk("berr", berr, m_err);
  endtask

  // one clock: inputs are already set by the caller
  task automatic tick();
    bit seen;
    bit n_busy;
    bit [W-1:0] n_data;
    bit n_req;
    bit n_done;
    bit n_err;
    int n_wait;
    seen   = m_hist[1];
    n_busy = m_busy;
    n_data = m_data;
    n_req  = m_req;
    n_done = 0;
    n_err  = m_err;
    n_wait = m_waited;
    if (!m_busy) begin
      if (bload && seen == m_req) begin
        n_busy = 1;
        n_data = bdin;
        n_req  = !m_req;
        n_wait = 0;
      end
    end else begin
      n_wait = m_waited + 1;
      if (TO_EN && n_wait >= T) n_err = 1;
      if (seen == m_req) begin
        n_busy = 0;
        n_done = 1;
      end
    end
    @(posedge bclk);
    if (brst_n) begin
      m_hist[1] = m_hist[0];
      m_hist[0] = a_ack;
      m_busy    = n_busy;
      m_data    = n_data;
      m_req     = n_req;
      m_done    = n_done;
      m_err     = n_err;
      m_waited  = n_wait;
    end
    @(negedge bclk);
    check_all();
  endtask

  task automatic do_reset();
    brst_n = 1'b0;
    a_ack  = 1'b0;
    bload  = 1'b0;
    model_reset();
    repeat (2) @(negedge bclk);
    brst_n = 1'b1;
  endtask

  int lat;
  int dones;
  int dly;
  int nxt;
  bit [W-1:0] got_q[$];
  bit req_q[$];
  bit saw_done;

  initial begin
    checks   = 0;
    failures = 0;
    bdin     = '0;
    bload    = 1'b0;
    a_ack    = 1'b0;
    brst_n   = 1'b0;
    model_reset();
    @(negedge bclk);
    #1;
    chk("rst_bdata", bdata, 0);
    chk("rst_b_req", b_req, 0);
    chk("rst_bdone", bdone, 0);
    chk("rst_berr", berr, 0);
    @(negedge bclk);
    brst_n = 1'b1;
    @(negedge bclk);
    chk("rel_bready", bready, 1);

    // first transfer
    bload = 1'b1;
    bdin  = 8'hA5;
    tick();
    chk("a5_bdata", bdata, 8'hA5);
    chk("a5_b_req", b_req, 1);
    chk("a5_bready", bready, 0);

    // loads during the wait are ignored
    bdin = 8'h3C;
    tick();
    tick();
    chk("ign_bdata", bdata, 8'hA5);
    chk("ign_b_req", b_req, 1);
    bload = 1'b0;

    // ack toggle: ready after exactly three edges
    a_ack = 1'b1;
    lat   = 0;
    dones = 0;
    for (int n = 1; n <= 6; n++) begin
      tick();
      if (bdone) dones++;
      if (bready && lat == 0) lat = n;
    end
    chk("ack_latency", lat, 3);
    chk("ack_dones", dones, 1);
    chk("ack_bdata", bdata, 8'hA5);

    // three back-to-back transfers, ack after 4 cycles
    do_reset();
    @(negedge bclk);
    nxt = 1;
    dly = 0;
    dones = 0;
    got_q.delete();
    req_q.delete();
    for (int c = 0; c < 80 && dones < 3; c++) begin
      if (!m_busy && nxt <= 3) begin
        bload = 1'b1;
        bdin  = W'(nxt);
      end else begin
        bload = 1'b0;
      end
      if (a_ack != m_req) begin
        dly++;
        if (dly >= 4) begin
          a_ack = m_req;
          dly   = 0;
        end
      end
      if (bload && !m_busy && m_hist[1] == m_req) nxt++;
      tick();
      if (bload && bready == 1'b0 && req_q.size() < nxt - 1)
        req_q.push_back(b_req);
      if (bdone) begin
        dones++;
        got_q.push_back(bdata);
      end
    end
    bload = 1'b0;
    chk("b2b_dones", dones, 3);
    chk("b2b_nreq", req_q.size(), 3);
    if (req_q.size() == 3) begin
      chk("b2b_req0", req_q[0], 1);
      chk("b2b_req1", req_q[1], 0);
      chk("b2b_req2", req_q[2], 1);
    end
    if (got_q.size() == 3) begin
      for (int i = 0; i < 3; i++)
        chk("b2b_data", got_q[i], i + 1);
    end

    // ack withheld: timeout behaviour
    do_reset();
    @(negedge bclk);
    bload = 1'b1;
    bdin  = 8'h77;
    tick();
    bload = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == 9) chk("to_berr9", berr, 0);
      if (n == 10) chk("to_berr10", berr, TO_EN);
    end
    chk("to_wait", bready, 0);
    a_ack = 1'b1;
    saw_done = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (bdone) saw_done = 1;
    end
    chk("to_done", saw_done, 1);
    chk("to_berr_end", berr, TO_EN);

    // stale unmatched ack blocks a new start
    do_reset();
    a_ack = 1'b1;
    repeat (3) tick();
    bload = 1'b1;
    bdin  = 8'h5A;
    tick();
    tick();
    chk("stale_bready", bready, 1);
    chk("stale_b_req", b_req, 0);
    a_ack = 1'b0;
    repeat (3) tick();
    chk("stale_start", b_req, 1);
    bload = 1'b0;

    // reset two cycles into a wait abandons the transfer
    do_reset();
    @(negedge bclk);
    bload = 1'b1;
    bdin  = 8'hC3;
    tick();
    bload = 1'b0;
    tick();
    tick();
    brst_n = 1'b0;
    #1;
    chk("mid_bdata", bdata, 0);
    chk("mid_b_req", b_req, 0);
    chk("mid_bdone", bdone, 0);
    chk("mid_berr", berr, 0);
    chk("mid_bready", bready, 1);
    do_reset();
    repeat (4) tick();

    // randomized traffic with a variable-delay responder
    dly = 0;
    nxt = $urandom_range(0, 6);
    for (int c = 0; c < 400; c++) begin
      bload = 1'($urandom_range(0, 1));
      bdin  = W'($urandom);
      if (a_ack != m_req) begin
        if (dly >= nxt) begin
          a_ack = m_req;
          dly   = 0;
          nxt   = $urandom_range(0, 6);
        end else begin
          dly++;
        end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
